// File: rtl/bus_dbg_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_dbg_master_pkg
//  Description : Shared constants, state encoding and helpers for the
//                serial-command bus initiator (command/response bytes,
//                FSM states, byte selection from a 32-bit word).
//  Revision    : 1.0  initial release
// ============================================================================
package bus_dbg_master_pkg;

    localparam logic [7:0] c_cmd_wr  = 8'h57;
    localparam logic [7:0] c_cmd_rd  = 8'h52;
    localparam logic [7:0] c_rsp_ack = 8'h06;
    localparam logic [7:0] c_rsp_nak = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_REQ  = 3'd3,
        ST_BUS  = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    // Byte idx of a word, MSB first (idx 0 = bits [31:24]).
    function automatic logic [7:0] word_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_dbg_master.sv
`default_nettype none
// ============================================================================
//  Module      : bus_dbg_master
//  Description : Serial-command bus initiator. Decodes write (57 A3..A0
//                D3..D0) and read (52 A3..A0) frames from a UART byte
//                stream, performs one 32-bit bus transaction, and returns
//                ACK / read data / NAK bytes to a UART transmitter.
//  Ports       : clk, reset (async, active high)
//                rx_data/rx_valid          - received byte strobe
//                tx_data/tx_valid/tx_ready - response byte handshake
//                bus_req/bus_gnt           - arbiter request/grant
//                mem_valid/mem_wstrb/mem_addr/mem_wdata/mem_rdata/mem_ready
//                                          - SoC bus initiator side
//                busy                      - FSM not idle
//  Revision    : 1.0  initial release
// ============================================================================
module bus_dbg_master
    import bus_dbg_master_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        mem_valid,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);

    localparam int               c_tw    = $clog2(TIMEOUT);
    localparam logic [c_tw-1:0]  c_tlast = c_tw'(TIMEOUT - 1);
    localparam logic [c_tw-1:0]  c_tone  = c_tw'(1);

    state_t             r_state,     w_state;
    logic [1:0]         r_cnt,       w_cnt;
    logic               r_is_wr,     w_is_wr;
    logic               r_multi,     w_multi;     // response is 4 read-data bytes
    logic [31:0]        r_addr,      w_addr;
    logic [31:0]        r_data,      w_data;      // write data, then read data
    logic [c_tw-1:0]    r_tcnt,      w_tcnt;
    logic [7:0]         r_tx_data,   w_tx_data;
    logic               r_tx_valid,  w_tx_valid;
    logic               r_bus_req,   w_bus_req;
    logic               r_mem_valid, w_mem_valid;
    logic [3:0]         r_mem_wstrb, w_mem_wstrb;
    logic [31:0]        r_mem_addr,  w_mem_addr;
    logic [31:0]        r_mem_wdata, w_mem_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state;
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_is_wr     = r_is_wr;
        w_multi     = r_multi;
        w_addr      = r_addr;
        w_data      = r_data;
        w_tcnt      = r_tcnt;
        w_tx_data   = r_tx_data;
        w_tx_valid  = r_tx_valid;
        w_bus_req   = r_bus_req;
        w_mem_valid = r_mem_valid;
        w_mem_wstrb = r_mem_wstrb;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;

        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    w_cnt = 2'd0;
                    if (rx_data == c_cmd_wr || rx_data == c_cmd_rd) begin
                        w_is_wr = (rx_data == c_cmd_wr);
                        w_state = ST_ADDR;
                    end else begin
                        w_tx_data  = c_rsp_nak;
                        w_tx_valid = 1'b1;
                        w_multi    = 1'b0;
                        w_state    = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    w_addr = {r_addr[23:0], rx_data};
                    w_cnt  = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        if (r_is_wr) begin
                            w_state = ST_DATA;
                        end else begin
                            w_state   = ST_REQ;
                            w_bus_req = 1'b1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    w_data = {r_data[23:0], rx_data};
                    w_cnt  = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state   = ST_REQ;
                        w_bus_req = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // Address/data/strobe are latched here so they stay constant
                // for the whole mem_valid window.
                if (bus_gnt) begin
                    w_mem_valid = 1'b1;
                    w_mem_wstrb = r_is_wr ? 4'b1111 : 4'b0000;
                    w_mem_addr  = r_addr & 32'hFFFF_FFFC;
                    w_mem_wdata = r_data;
                    w_tcnt      = '0;
                    w_state     = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ready is tested first so it wins over the terminal count.
                if (mem_ready || r_tcnt == c_tlast) begin
                    w_mem_valid = 1'b0;
                    w_bus_req   = 1'b0;
                    w_mem_wstrb = 4'b0000;
                    w_tx_valid  = 1'b1;
                    w_state     = ST_RESP;
                    w_multi     = 1'b0;
                    if (!mem_ready) begin
                        w_tx_data = c_rsp_nak;
                    end else if (r_is_wr) begin
                        w_tx_data = c_rsp_ack;
                    end else begin
                        w_data    = mem_rdata;
                        w_tx_data = mem_rdata[31:24];
                        w_multi   = 1'b1;
                        w_cnt     = 2'd1;     // index of the next byte to send
                    end
                end else begin
                    w_tcnt = r_tcnt + c_tone;
                end
            end
            ST_RESP: begin
                if (r_tx_valid && tx_ready) begin
                    // cnt wraps to 0 after the fourth read byte is loaded.
                    if (r_multi && r_cnt != 2'd0) begin
                        w_tx_data = word_byte(r_data, r_cnt);
                        w_cnt     = r_cnt + 2'd1;
                    end else begin
                        w_tx_valid = 1'b0;
                        w_multi    = 1'b0;
                        w_state    = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= 2'd0;
            r_is_wr     <= 1'b0;
            r_multi     <= 1'b0;
            r_addr      <= 32'd0;
            r_data      <= 32'd0;
            r_tcnt      <= '0;
            r_tx_data   <= 8'd0;
            r_tx_valid  <= 1'b0;
            r_bus_req   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_wstrb <= 4'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_cnt       <= w_cnt;
            r_is_wr     <= w_is_wr;
            r_multi     <= w_multi;
            r_addr      <= w_addr;
            r_data      <= w_data;
            r_tcnt      <= w_tcnt;
            r_tx_data   <= w_tx_data;
            r_tx_valid  <= w_tx_valid;
            r_bus_req   <= w_bus_req;
            r_mem_valid <= w_mem_valid;
            r_mem_wstrb <= w_mem_wstrb;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign bus_req   = r_bus_req;
    assign mem_valid = r_mem_valid;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_dbg_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_dbg_master
//  Description : Directed self-checking bench for bus_dbg_master.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_dbg_master;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic        mem_valid;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [7:0]  txq[$];

    bus_dbg_master #(.TIMEOUT(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .mem_valid (mem_valid),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic wait_mv();
        int k;
        k = 0;
        while (mem_valid !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk("mv_seen", 32'(mem_valid), 32'd1);
    endtask

    // Hold the transaction; assert mem_ready during the ready_at-th visible
    // cycle of mem_valid (0 = never). n returns the number of high cycles.
    task automatic run_bus(input int ready_at, input logic [31:0] rd, output int n);
        n = 0;
        mem_rdata = rd;
        while (mem_valid === 1'b1 && n < 1100) begin
            n++;
            mem_ready = (n == ready_at);
            tick();
        end
        mem_ready = 1'b0;
    endtask

    // Record every byte accepted over a fixed window.
    task automatic collect_tx(input int cycles, input bit toggle);
        txq.delete();
        for (int i = 0; i < cycles; i++) begin
            tx_ready = toggle ? ~i[0] : 1'b1;
            if (tx_valid === 1'b1 && tx_ready === 1'b1) txq.push_back(tx_data);
            tick();
        end
        tx_ready = 1'b0;
    endtask

    task automatic check_bytes(input int n, input logic [31:0] w);
        chk("tx_count", 32'(txq.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [7:0] got;
            got = (i < txq.size()) ? txq[i] : 8'hxx;
            chk("tx_byte", {24'd0, got}, {24'd0, w[31-8*i -: 8]});
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] rd);
        int n;
        send_byte(8'h52);
        send_word(a);
        wait_mv();
        chk("rd_addr", mem_addr, a & 32'hFFFF_FFFC);
        chk("rd_wstrb", 32'(mem_wstrb), 32'h0);
        run_bus(2, rd, n);
        chk("rd_width", 32'(n), 32'd2);
        collect_tx(20, 1'b1);
        check_bytes(4, rd);
        chk("rd_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unstable;
        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        bus_gnt   = 1'b1;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;
        tick();
        tick();
        // Reset values
        chk("rst_tx_data",   32'(tx_data),   32'h0);
        chk("rst_tx_valid",  32'(tx_valid),  32'h0);
        chk("rst_bus_req",   32'(bus_req),   32'h0);
        chk("rst_mem_valid", 32'(mem_valid), 32'h0);
        chk("rst_wstrb",     32'(mem_wstrb), 32'h0);
        chk("rst_addr",      mem_addr,       32'h0);
        chk("rst_wdata",     mem_wdata,      32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        reset = 1'b0;
        tick();

        // Write frame, grant already high, ready in the 4th cycle
        send_byte(8'h57);
        send_word(32'h0000_0010);
        send_word(32'hDEAD_BEEF);
        chk("wr_req_rise", 32'(bus_req),   32'd1);
        chk("wr_mv_early", 32'(mem_valid), 32'd0);
        tick();
        chk("wr_mv_rise",  32'(mem_valid), 32'd1);
        chk("wr_addr",     mem_addr,       32'h0000_0010);
        chk("wr_wdata",    mem_wdata,      32'hDEAD_BEEF);
        chk("wr_wstrb",    32'(mem_wstrb), 32'hF);
        unstable = 0;
        n = 0;
        while (mem_valid === 1'b1 && n < 50) begin
            if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF || mem_wstrb !== 4'hF)
                unstable++;
            n++;
            mem_ready = (n == 4);
            tick();
        end
        mem_ready = 1'b0;
        chk("wr_stable",   32'(unstable),  32'd0);
        chk("wr_width",    32'(n),         32'd4);
        chk("wr_req_fall", 32'(bus_req),   32'd0);
        chk("wr_wstrb_clr",32'(mem_wstrb), 32'h0);
        chk("wr_txv",      32'(tx_valid),  32'd1);
        collect_tx(8, 1'b0);
        check_bytes(1, 32'h0600_0000);
        chk("wr_idle",     32'(busy),      32'd0);

        // Read frame, tx_ready toggling
        do_read(32'h0001_0000, 32'h1234_5678);

        // Bad command, then a clean read
        send_byte(8'h41);
        chk("nak_txv",  32'(tx_valid), 32'd1);
        chk("nak_data", 32'(tx_data),  32'h15);
        chk("nak_req",  32'(bus_req),  32'd0);
        collect_tx(8, 1'b0);
        check_bytes(1, 32'h1500_0000);
        do_read(32'h0000_0020, 32'hAABB_CCDD);

        // Bus timeout: no responder
        send_byte(8'h52);
        send_word(32'h0000_0007);
        wait_mv();
        chk("to_addr", mem_addr, 32'h0000_0004);
        run_bus(0, 32'h0, n);
        chk("to_width", 32'(n), 32'd1024);
        chk("to_req",   32'(bus_req), 32'd0);
        collect_tx(10, 1'b0);
        check_bytes(1, 32'h1500_0000);

        // Ready on the terminal cycle wins
        send_byte(8'h52);
        send_word(32'h0000_0007);
        wait_mv();
        run_bus(1024, 32'hCAFE_F00D, n);
        chk("tr_width", 32'(n), 32'd1024);
        collect_tx(20, 1'b1);
        check_bytes(4, 32'hCAFE_F00D);

        // Grant held low with rx bytes injected during the wait
        bus_gnt = 1'b0;
        send_byte(8'h52);
        send_word(32'h0000_0030);
        for (int i = 0; i < 20; i++) begin
            if (i == 3)       send_byte(8'h57);
            else if (i == 7)  send_byte(8'h52);
            else if (i == 11) send_byte(8'h41);
            else              tick();
            chk("gnt_wait_mv", 32'(mem_valid), 32'd0);
        end
        chk("gnt_wait_req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        tick();
        chk("gnt_mv_rise", 32'(mem_valid), 32'd1);
        chk("gnt_addr",    mem_addr,       32'h0000_0030);
        run_bus(1, 32'h0BAD_CAFE, n);
        chk("gnt_width", 32'(n), 32'd1);
        collect_tx(20, 1'b1);
        check_bytes(4, 32'h0BAD_CAFE);
        chk("gnt_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-transaction
        send_byte(8'h57);
        send_word(32'h0000_0040);
        send_word(32'h1122_3344);
        wait_mv();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_mv",  32'(mem_valid), 32'd0);
        chk("arst_req", 32'(bus_req),   32'd0);
        #1 reset = 1'b0;
        tick();
        collect_tx(10, 1'b0);
        chk("arst_no_tx", 32'(txq.size()), 32'd0);
        chk("arst_idle",  32'(busy),       32'd0);
        do_read(32'h0000_0044, 32'h5566_7788);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
